// File: rtl/gf_pkg.sv
// ============================================================================
// Module : gf_pkg
// Brief  : Shared defaults, FSM state type and leading-one helper for GF(2^M)
//          exponentiation.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package gf_pkg;

    localparam int         GF_M_DEFAULT    = 4;
    localparam logic [4:0] GF_POLY_DEFAULT = 5'b10011;   // x^4 + x + 1

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } gf_exp_state_t;

    // Bit-length of v: index of the highest set bit plus one, 0 when v == 0.
    function automatic int gf_bitlen(input logic [31:0] v);
        int n;
        n = 0;
        for (int i = 0; i < 32; i++) begin
            if (v[i]) n = i + 1;
        end
        return n;
    endfunction

endpackage

`default_nettype wire

// File: rtl/gf2m_mulmod.sv
// ============================================================================
// Module : gf2m_mulmod
// Brief  : Combinational GF(2^M) multiplier, carry-less product reduced by POLY.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module gf2m_mulmod
    import gf_pkg::*;
#(
    parameter int         M    = GF_M_DEFAULT,
    parameter logic [M:0] POLY = GF_POLY_DEFAULT
) (
    input  logic [M-1:0] x,
    input  logic [M-1:0] y,
    output logic [M-1:0] p
);

    logic [M-1:0] w_acc;

    // Horner form, MSB of y first: shift (reducing x^M back into the field), then add x.
    always_comb begin
        w_acc = '0;
        for (int i = M - 1; i >= 0; i--) begin
            w_acc = (w_acc << 1)
                  ^ (w_acc[M-1] ? POLY[M-1:0] : '0)
                  ^ (y[i] ? x : '0);
        end
    end

    assign p = w_acc;

endmodule

`default_nettype wire

// File: rtl/gf2m_exp_seq.sv
// ============================================================================
// Module : gf2m_exp_seq
// Brief  : Sequential GF(2^M) exponentiation Z = A^E mod P, MSB-first
//          square-and-multiply, one exponent bit per clock.
//          Optional macro GF_EXP_SKIP_LZ_EN skips leading zero exponent bits.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module gf2m_exp_seq
    import gf_pkg::*;
#(
    parameter int         M    = GF_M_DEFAULT,
    parameter logic [M:0] POLY = GF_POLY_DEFAULT,
    parameter int         EW   = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [M-1:0]  a,
    input  logic [EW-1:0] e,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [M-1:0]  z,
    output logic          busy
);

    localparam int c_cnt_w = $clog2(EW + 1);

    gf_exp_state_t      r_state;
    gf_exp_state_t      w_state_nxt;

    logic [M-1:0]       r_acc;
    logic [M-1:0]       r_base;
    logic [M-1:0]       r_z;
    logic [EW-1:0]      r_exp_sh;
    logic [c_cnt_w-1:0] r_cnt;

    logic [M-1:0]       w_sq;
    logic [M-1:0]       w_mul;
    logic [M-1:0]       w_acc_nxt;
    logic [c_cnt_w-1:0] w_cnt_load;
    logic [EW-1:0]      w_exp_load;
    logic               w_accept;
    logic               w_last;

    gf2m_mulmod #(.M(M), .POLY(POLY)) u_sq (
        .x (r_acc),
        .y (r_acc),
        .p (w_sq)
    );

    gf2m_mulmod #(.M(M), .POLY(POLY)) u_mul (
        .x (w_sq),
        .y (r_base),
        .p (w_mul)
    );

    assign w_acc_nxt = r_exp_sh[EW-1] ? w_mul : w_sq;
    assign w_accept  = in_valid && in_ready;
    assign w_last    = (r_cnt == c_cnt_w'(1));

`ifdef GF_EXP_SKIP_LZ_EN
    int w_bitlen;

    // e == 0 still runs one squaring of acc = 1 so the result path is shared.
    assign w_bitlen   = gf_bitlen(32'(e));
    assign w_cnt_load = (w_bitlen == 0) ? c_cnt_w'(1) : c_cnt_w'(w_bitlen);
    assign w_exp_load = e << (EW - w_bitlen);
`else
    assign w_cnt_load = c_cnt_w'(EW);
    assign w_exp_load = e;
`endif

    // State register
    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_nxt;
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_accept)  w_state_nxt = RUN;
            RUN:     if (w_last)    w_state_nxt = DONE;
            DONE:    if (out_ready) w_state_nxt = IDLE;
            default:                w_state_nxt = IDLE;
        endcase
    end

    // Datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc    <= M'(1);
            r_base   <= '0;
            r_exp_sh <= '0;
            r_cnt    <= '0;
            r_z      <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_base   <= a;
                        r_acc    <= M'(1);
                        r_exp_sh <= w_exp_load;
                        r_cnt    <= w_cnt_load;
                    end
                end
                RUN: begin
                    r_acc    <= w_acc_nxt;
                    r_exp_sh <= r_exp_sh << 1;
                    r_cnt    <= r_cnt - c_cnt_w'(1);
                    if (w_last) r_z <= w_acc_nxt;
                end
                default: ;
            endcase
        end
    end

    // Output logic
    always_comb begin
        in_ready  = (r_state == IDLE) && !rst;
        out_valid = (r_state == DONE);
        busy      = (r_state == RUN) || (r_state == DONE);
    end

    assign z = r_z;

endmodule

`default_nettype wire

// File: tb/tb_gf2m_exp_seq.sv
// ============================================================================
// Module : tb_gf2m_exp_seq
// Brief  : Self-checking bench for gf2m_exp_seq against a repeated-multiply
//          GF(2^4) reference model.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_gf2m_exp_seq;

    localparam int M  = 4;
    localparam int EW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [M-1:0]  a;
    logic [EW-1:0] e;
    logic          out_valid;
    logic          out_ready;
    logic [M-1:0]  z;
    logic          busy;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    gf2m_exp_seq #(.M(M), .POLY(5'b10011), .EW(EW)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .e         (e),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .z         (z),
        .busy      (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input int got, input int expv);
        n_checks++;
        if (got == expv) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, expv);
    endtask

    // Polynomial product of x and y in GF(2)[x], reduced modulo x^4+x+1.
    function automatic int ref_mul(input int x, input int y);
        int r;
        r = 0;
        for (int i = 0; i < 4; i++)
            if (((y >> i) & 1) != 0) r = r ^ (x << i);
        for (int i = 6; i >= 4; i--)
            if (((r >> i) & 1) != 0) r = r ^ ('h13 << (i - 4));
        return r;
    endfunction

    function automatic int ref_pow(input int base, input int ex);
        int r;
        r = 1;
        for (int i = 0; i < ex; i++) r = ref_mul(r, base);
        return r;
    endfunction

    function automatic int ref_lat(input int ex);
`ifdef GF_EXP_SKIP_LZ_EN
        int bl;
        bl = 0;
        for (int i = 0; i < EW; i++)
            if (((ex >> i) & 1) != 0) bl = i + 1;
        return (bl == 0) ? 1 : bl;
`else
        return (ex >= 0) ? EW : EW;
`endif
    endfunction

    task automatic wait_in_ready();
        int n;
        n = 0;
        while (!in_ready && n < 64) begin
            @(posedge clk); #1;
            n++;
        end
        if (!in_ready) check("timeout_in_ready", 0, 1);
    endtask

    task automatic wait_out(output int lat);
        lat = 0;
        do begin
            @(posedge clk); #1;
            lat++;
        end while (!out_valid && lat < 64);
        if (!out_valid) check("timeout_out_valid", 0, 1);
    endtask

    // One request with out_ready high; result compared to a given constant.
    task automatic do_req(input logic [3:0] ai, input logic [3:0] ei, input int expz, input string tag);
        int lat;
        wait_in_ready();
        in_valid = 1'b1; a = ai; e = ei;
        @(posedge clk); #1;
        in_valid = 1'b0;
        wait_out(lat);
        check({tag, "_lat"}, lat, ref_lat(int'(ei)));
        check({tag, "_z"}, int'(z), expz);
        @(posedge clk); #1;
        check({tag, "_ov_drop"}, int'(out_valid), 0);
    endtask

    initial begin
        int lat, zhold, acc_cyc, prev_cyc, prev_e;

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; a = '0; e = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", int'(in_ready), 0);
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_z", int'(z), 0);
        check("rst_busy", int'(busy), 0);
        rst = 1'b0;
        #1;
        check("post_rst_in_ready", int'(in_ready), 1);

        do_req(4'b0010, 4'b0011, 'b1000, "a2e3");
        do_req(4'b0010, 4'b0100, 'b0011, "a2e4");
        do_req(4'b0010, 4'b1111, 'b0001, "a2e15");
        do_req(4'b0010, 4'b1110, 'b1001, "a2e14");
        do_req(4'b0011, 4'b0010, 'b0101, "a3e2");
        do_req(4'b0000, 4'b0101, 'b0000, "a0e5");
        do_req(4'b1011, 4'b0000, 'b0001, "a11e0");
        do_req(4'b0000, 4'b0000, 'b0001, "a0e0");
        do_req(4'b0001, 4'b1101, 'b0001, "a1e13");
        do_req(4'b0010, 4'b0001, 'b0010, "a2e1");

        // Back-pressure with stray in_valid during RUN and DONE
        wait_in_ready();
        out_ready = 1'b0;
        in_valid = 1'b1; a = 4'b0010; e = 4'b1110;
        @(posedge clk); #1;
        a = 4'b0101; e = 4'b0011;
        wait_out(lat);
        check("bp_z", int'(z), 'b1001);
        zhold = int'(z);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check("bp_ov_hold", int'(out_valid), 1);
            check("bp_z_hold", int'(z), zhold);
            check("bp_in_ready", int'(in_ready), 0);
            check("bp_busy", int'(busy), 1);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("bp_release_ov", int'(out_valid), 0);
        check("bp_release_busy", int'(busy), 0);
        check("bp_release_in_ready", int'(in_ready), 1);

        // Reset in the middle of a RUN
        in_valid = 1'b1; a = 4'b0010; e = 4'b1110;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        check("mid_busy", int'(busy), 1);
        rst = 1'b1;
        @(posedge clk); #1;
        check("mid_rst_ov", int'(out_valid), 0);
        check("mid_rst_z", int'(z), 0);
        check("mid_rst_busy", int'(busy), 0);
        check("mid_rst_in_ready", int'(in_ready), 0);
        rst = 1'b0;
        #1;
        check("mid_rel_in_ready", int'(in_ready), 1);
        do_req(4'b0010, 4'b1110, 'b1001, "after_rst");

        // Exhaustive sweep with in_valid held high, compared to the model
        prev_cyc = 0; prev_e = 0;
        in_valid = 1'b1;
        for (int ai = 0; ai < 16; ai++) begin
            for (int ei = 0; ei < 16; ei++) begin
                a = 4'(ai); e = 4'(ei);
                wait_in_ready();
                @(posedge clk); #1;
                acc_cyc = cyc;
                if (ai != 0 || ei != 0)
                    check("sweep_spacing", acc_cyc - prev_cyc, ref_lat(prev_e) + 2);
                prev_cyc = acc_cyc;
                prev_e = ei;
                wait_out(lat);
                check("sweep_lat", lat, ref_lat(ei));
                check("sweep_z", int'(z), ref_pow(ai, ei));
            end
        end
        in_valid = 1'b0;
        @(posedge clk); #1;
        check("sweep_end_idle", int'(in_ready), 1);

        // A few random requests, with random back-pressure lengths
        for (int k = 0; k < 20; k++) begin
            int ra, re, stall;
            ra = int'($urandom_range(15, 0));
            re = int'($urandom_range(15, 0));
            stall = int'($urandom_range(3, 0));
            wait_in_ready();
            out_ready = 1'b0;
            in_valid = 1'b1; a = 4'(ra); e = 4'(re);
            @(posedge clk); #1;
            in_valid = 1'b0;
            wait_out(lat);
            repeat (stall) begin @(posedge clk); #1; end
            check("rand_ov", int'(out_valid), 1);
            check("rand_z", int'(z), ref_pow(ra, re));
            out_ready = 1'b1;
            @(posedge clk); #1;
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/gf2m_exp_seq.md
Name: gf2m_exp_seq

Overview:
- Sequential GF(2^M) exponentiation unit: computes Z = A^E mod P(x) by MSB-first square-and-multiply, one exponent bit per clock.
- Parametrised successor of the team's fixed 4-bit combinational squarer. Generalises field width and reduction polynomial, adds arbitrary exponents and valid/ready handshakes.
- Sits between operand staging and the field-arithmetic datapath. Serves power and inverse requests, where the inverse is A^(2^M-2).

Parameters:
- M, 4, field degree; operand and result width in bits.
- POLY, 5'b10011, irreducible polynomial P(x), M+1 bits, MSB must be 1. Default is x^4+x+1.
- EW, 4, exponent width in bits; EW >= 1.

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  request valid.
- in_ready  out  1  unit can accept a request.
- a  in  M  base operand.
- e  in  EW  exponent.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- z  out  M  result A^E mod P.
- busy  out  1  high in RUN or DONE.

Behaviour:
- Reset values: in_ready=0 during the reset cycle and 1 after it; out_valid=0; z=0; busy=0; state=IDLE. Internal acc=1, base=0, exp_sh=0, cnt=0.
- State IDLE:
  - in_ready=1.
  - On in_valid&in_ready at an edge: base<=a, exp_sh<=e, acc<=1, cnt<=EW, go to RUN.
  - Inputs a and e are sampled only at the accept edge.
- State RUN:
  - in_ready=0.
  - Each edge: acc <= exp_sh[EW-1] ? mulmod(sqmod(acc), base) : sqmod(acc); exp_sh<=exp_sh<<1; cnt<=cnt-1.
  - At the edge where cnt goes 1->0: z<=next acc, go to DONE.
- State DONE:
  - out_valid=1; z held stable while out_valid=1 && out_ready=0.
  - On out_ready at an edge: out_valid<=0, go to IDLE.
  - No new request is accepted in the same cycle as the result handshake, so in_ready rises the following cycle.
- Latency: out_valid rises exactly EW cycles after the accept edge; this is fixed and data-independent. Throughput is one result per EW+2 cycles with out_ready held high.
- Arithmetic:
  - mulmod is a carry-less M x M product reduced by POLY into M bits; sqmod(x) = mulmod(x,x).
  - The whole squaring-then-multiply is a single-cycle combinational path.
- Boundary cases:
  - e=0 gives z=1 for any a, including 0^0=1.
  - a=0 with e!=0 gives z=0.
  - a=1 gives z=1.
- Handshake rules:
  - in_valid asserted outside IDLE is ignored; no queuing.
  - out_ready outside DONE is ignored.
  - out_valid, once high, must not drop before the handshake.
- Reset mid-operation (RUN or DONE): the next edge returns to IDLE with all outputs at reset values; the in-flight result is discarded.
- Width rule: all internal registers are M bits except exp_sh (EW bits) and cnt (clog2(EW+1) bits).

Optional Feature:
- Macro GF_EXP_SKIP_LZ_EN.
- Defined:
  - At accept, cnt<=bit-length of e (index of highest set bit + 1) and exp_sh<=e left-aligned so that bit becomes the MSB. Leading zeros cost no cycles.
  - Latency is max(1, bitlen(e)) cycles.
  - e=0 takes 1 cycle: one RUN cycle squaring acc=1, result 1.
- Undefined: fixed EW-cycle latency as above.
- Results are identical in both builds; only timing differs.

Decomposition:
- Package gf_pkg: default M, default POLY, and state typedef gf_exp_state_t {IDLE, RUN, DONE}. Leading-one detector function for the optional feature.
- One sub-module, gf2m_mulmod: combinational, parameters M and POLY, inputs x[M-1:0] and y[M-1:0], output p[M-1:0].
  - Instantiated twice: one instance squares (x=y=acc), the other multiplies by base.
  - Reusable elsewhere in the field datapath.

Test Plan (M=4, POLY=10011, EW=4, out_ready=1 unless stated):
- a=0010, e=0011 -> out_valid 4 cycles after accept, z=1000. Then a=0010, e=0100 -> z=0011.
- a=0010, e=1111 -> z=0001 (alpha has order 15). a=0010, e=1110 -> z=1001 (inverse; check 0010*1001=0001).
- a=0011, e=0010 -> z=0101. a=0000, e=0101 -> z=0000. a=1011, e=0000 -> z=0001.
- Back-pressure: out_ready low 5 cycles after out_valid -> z and out_valid stable, in_ready=0 throughout. in_valid pulses during RUN/DONE are ignored. out_ready high -> IDLE next cycle.
- Reset asserted mid-RUN (cycle 2 of a=0010, e=1110) -> next cycle state=IDLE, out_valid=0, z=0, in_ready=1 after release. A new request then yields the correct result.
- Back-to-back (exhaustive sweep): all 16 a x 16 e against a software reference, in_valid held high -> every result correct, accept-to-accept spacing EW+2 cycles. With GF_EXP_SKIP_LZ_EN: e=0001 latency 1, e=0100 latency 3.
